// File: rtl/temp_ctrl_pkg.sv
// Shared definitions for the temperature control loops.
// Holds the controller FSM state type, duty/integrator widths and limits, and
// the saturation/clamp helpers used by the PI datapath.
package temp_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StErr,
        StMul,
        StAcc,
        StOut
    } ctrl_state_e;

    localparam int unsigned DUTY_W = 16;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 16'hFFFF;

    localparam int unsigned INTEG_W = 32;
    localparam logic signed [INTEG_W-1:0] INTEG_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [INTEG_W-1:0] INTEG_MIN = 32'sh8000_0000;

    // Working width for integrator and final sums (two guard bits over INTEG_W).
    localparam int unsigned ACC_W = INTEG_W + 2;

    // Saturate an ACC_W signed value to the signed integrator range.
    function automatic logic signed [INTEG_W-1:0] sat_integ(
        input logic signed [ACC_W-1:0] x
    );
        logic [ACC_W-INTEG_W:0] top;
        top = x[ACC_W-1:INTEG_W-1];
        if (top == '0 || top == '1) begin
            return $signed(x[INTEG_W-1:0]);
        end else if (x[ACC_W-1]) begin
            return INTEG_MIN;
        end else begin
            return INTEG_MAX;
        end
    endfunction

    // Clamp an ACC_W signed value to the unsigned duty range [0, DUTY_MAX].
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic signed [ACC_W-1:0] x);
        if (x[ACC_W-1]) begin
            return '0;
        end else if (|x[ACC_W-2:DUTY_W]) begin
            return DUTY_MAX;
        end else begin
            return x[DUTY_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pi_duty_controller.sv
// PI controller producing a saturated 16-bit heater duty word.
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   enable            - loop enable, latched with each sample
//   sample_valid      - strobe qualifying temp/setpoint
//   temp, setpoint    - unsigned temperature codes
//   duty              - registered duty word for the PWM stage
//   duty_valid        - one-cycle pulse when duty was updated
//   busy              - computation in flight
//   overrun           - registered pulse for a strobe dropped while busy
module pi_duty_controller
    import temp_ctrl_pkg::*;
#(
    parameter int unsigned TEMP_W = 12,
    parameter logic [15:0] KP     = 16'd256,
    parameter logic [15:0] KI     = 16'd16,
    parameter int unsigned FRAC   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] temp,
    input  logic [TEMP_W-1:0] setpoint,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned ERR_W  = TEMP_W + 1;
    localparam int unsigned PROD_W = TEMP_W + 17;

    ctrl_state_e               state_q, state_d;
    logic [TEMP_W-1:0]         temp_q, temp_d;
    logic [TEMP_W-1:0]         setpoint_q, setpoint_d;
    logic                      en_q, en_d;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic signed [PROD_W-1:0]  p_q, p_d;
    logic signed [PROD_W-1:0]  i_inc_q, i_inc_d;
    logic [DUTY_W-1:0]         duty_acc_q, duty_acc_d;
    logic signed [INTEG_W-1:0] integ_acc_q, integ_acc_d;
    logic [DUTY_W-1:0]         duty_q, duty_d;
    logic signed [INTEG_W-1:0] integ_q, integ_d;
    logic                      duty_valid_q, duty_valid_d;
    logic                      overrun_q, overrun_d;

    // Datapath
    logic signed [ERR_W-1:0]   err_calc;
    logic signed [PROD_W-1:0]  p_calc, i_inc_calc;
    logic signed [ACC_W-1:0]   p_ext, i_inc_ext, integ_ext, integ_sum, integ_c_ext, sum, u;
    logic signed [INTEG_W-1:0] integ_c;
    logic                      u_hi, u_lo, err_pos, err_neg, hold_integ;

    assign err_calc    = {1'b0, setpoint_q} - {1'b0, temp_q};
    assign p_calc      = $signed({1'b0, KP}) * err_q;
    assign i_inc_calc  = $signed({1'b0, KI}) * err_q;

    assign p_ext       = {{(ACC_W - PROD_W){p_q[PROD_W-1]}}, p_q};
    assign i_inc_ext   = {{(ACC_W - PROD_W){i_inc_q[PROD_W-1]}}, i_inc_q};
    assign integ_ext   = {{(ACC_W - INTEG_W){integ_q[INTEG_W-1]}}, integ_q};
    assign integ_sum   = i_inc_ext + integ_ext;
    assign integ_c     = sat_integ(integ_sum);
    assign integ_c_ext = {{(ACC_W - INTEG_W){integ_c[INTEG_W-1]}}, integ_c};
    assign sum         = p_ext + integ_c_ext;
    assign u           = sum >>> FRAC;

    assign u_lo        = u[ACC_W-1];
    assign u_hi        = !u[ACC_W-1] && (|u[ACC_W-2:DUTY_W]);
    assign err_neg     = err_q[ERR_W-1];
    assign err_pos     = !err_q[ERR_W-1] && (|err_q);
    // Anti-windup: freeze the integrator while it would push further into a rail.
    assign hold_integ  = (u_hi && err_pos) || (u_lo && err_neg);

    always_comb begin
        state_d      = state_q;
        temp_d       = temp_q;
        setpoint_d   = setpoint_q;
        en_d         = en_q;
        err_d        = err_q;
        p_d          = p_q;
        i_inc_d      = i_inc_q;
        duty_acc_d   = duty_acc_q;
        integ_acc_d  = integ_acc_q;
        duty_d       = duty_q;
        integ_d      = integ_q;
        duty_valid_d = 1'b0;
        overrun_d    = sample_valid && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (sample_valid) begin
                    temp_d     = temp;
                    setpoint_d = setpoint;
                    en_d       = enable;
                    state_d    = StErr;
                end
            end
            StErr: begin
                err_d   = err_calc;
                state_d = StMul;
            end
            StMul: begin
                p_d     = p_calc;
                i_inc_d = i_inc_calc;
                state_d = StAcc;
            end
            StAcc: begin
                duty_acc_d  = clamp_duty(u);
                integ_acc_d = hold_integ ? integ_q : integ_c;
                state_d     = StOut;
            end
            StOut: begin
                duty_d       = en_q ? duty_acc_q : '0;
                integ_d      = en_q ? integ_acc_q : '0;
                duty_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            temp_q       <= '0;
            setpoint_q   <= '0;
            en_q         <= 1'b0;
            err_q        <= '0;
            p_q          <= '0;
            i_inc_q      <= '0;
            duty_acc_q   <= '0;
            integ_acc_q  <= '0;
            duty_q       <= '0;
            integ_q      <= '0;
            duty_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            temp_q       <= temp_d;
            setpoint_q   <= setpoint_d;
            en_q         <= en_d;
            err_q        <= err_d;
            p_q          <= p_d;
            i_inc_q      <= i_inc_d;
            duty_acc_q   <= duty_acc_d;
            integ_acc_q  <= integ_acc_d;
            duty_q       <= duty_d;
            integ_q      <= integ_d;
            duty_valid_q <= duty_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = duty_valid_q;
    assign busy       = (state_q != StIdle);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pi_duty_controller.sv
module tb_pi_duty_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sample_valid;
    logic [11:0] temp;
    logic [11:0] setpoint;
    logic [15:0] duty, duty_h;
    logic        duty_valid, duty_valid_h;
    logic        busy, busy_h;
    logic        overrun, overrun_h;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp_h_q[$];
    longint      integ_m;
    longint      integ_h_m;

    always #5 clk = ~clk;

    pi_duty_controller dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_valid(sample_valid),
        .temp        (temp),
        .setpoint    (setpoint),
        .duty        (duty),
        .duty_valid  (duty_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    pi_duty_controller #(.KP(16'hFFFF)) dut_hi (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_valid(sample_valid),
        .temp        (temp),
        .setpoint    (setpoint),
        .duty        (duty_h),
        .duty_valid  (duty_valid_h),
        .busy        (busy_h),
        .overrun     (overrun_h)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference PI step with KI = 16, FRAC = 8.
    task automatic model(input longint kp, input int sp, input int t, input bit en,
                         inout longint integ, output logic [15:0] d);
        longint err, p, inc, ic, s, u;
        err = longint'(sp) - longint'(t);
        p   = kp * err;
        inc = 16 * err;
        ic  = integ + inc;
        if (ic > 64'sd2147483647) ic = 64'sd2147483647;
        if (ic < -64'sd2147483648) ic = -64'sd2147483648;
        s = p + ic;
        u = s >>> 8;
        if (!en) begin
            d     = 16'd0;
            integ = 0;
        end else begin
            if (u < 0) d = 16'd0;
            else if (u > 65535) d = 16'hFFFF;
            else d = u[15:0];
            if (!((u > 65535 && err > 0) || (u < 0 && err < 0))) integ = ic;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && duty_valid) begin
            if (exp_q.size() == 0) check("dv_unexpected", 32'd1, 32'd0);
            else check("duty", {16'd0, duty}, {16'd0, exp_q.pop_front()});
        end
        if (!reset && duty_valid_h) begin
            if (exp_h_q.size() == 0) check("dv_hi_unexpected", 32'd1, 32'd0);
            else check("duty_hi", {16'd0, duty_h}, {16'd0, exp_h_q.pop_front()});
        end
    end

    task automatic push_expect(input int sp, input int t, input bit en);
        logic [15:0] d;
        model(64'd256, sp, t, en, integ_m, d);
        exp_q.push_back(d);
        model(64'd65535, sp, t, en, integ_h_m, d);
        exp_h_q.push_back(d);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        #1;
        check("rst_duty", {16'd0, duty}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dv", {31'd0, duty_valid}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        integ_m   = 0;
        integ_h_m = 0;
        exp_q.delete();
        exp_h_q.delete();
    endtask

    // Call #1 after a rising edge; returns #1 after the edge that shows duty_valid.
    task automatic run_sample(input int sp, input int t, input bit en);
        setpoint     = sp[11:0];
        temp         = t[11:0];
        enable       = en;
        sample_valid = 1'b1;
        push_expect(sp, t, en);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        temp         = ~temp;  // must not affect the accepted sample
        setpoint     = ~setpoint;
        enable       = ~enable;
        check("busy_e0", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check("dv_early", {31'd0, duty_valid}, 32'd0);
            check("busy_mid", {31'd0, busy}, 32'd1);
        end
        @(posedge clk);
        #1;
        check("dv_e4", {31'd0, duty_valid}, 32'd1);
        check("busy_e4", {31'd0, busy}, 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        temp         = '0;
        setpoint     = '0;
        integ_m      = 0;
        integ_h_m    = 0;

        // Proportional + first integral step: 106 then 112
        do_reset();
        run_sample(1000, 900, 1'b1);
        idle_cycles(2);
        run_sample(1000, 900, 1'b1);
        idle_cycles(2);
        check("duty_hold", {16'd0, duty}, 32'd112);

        // Negative error clamps low and the integrator stays at zero
        do_reset();
        run_sample(500, 900, 1'b1);
        idle_cycles(1);
        run_sample(1000, 900, 1'b1);
        idle_cycles(1);

        // High saturation, then zero error shows no windup tail
        do_reset();
        run_sample(4095, 0, 1'b1);
        idle_cycles(1);
        check("hi_sat", {16'd0, duty_h}, 32'd65535);
        run_sample(2000, 2000, 1'b1);
        idle_cycles(1);
        check("hi_no_windup", {16'd0, duty_h}, 32'd0);

        // Overrun: second strobe two cycles later is dropped
        do_reset();
        setpoint     = 12'd1000;
        temp         = 12'd900;
        enable       = 1'b1;
        sample_valid = 1'b1;
        push_expect(1000, 900, 1'b1);
        @(posedge clk); #1;            // E0
        sample_valid = 1'b0;
        @(posedge clk); #1;            // E1
        sample_valid = 1'b1;
        setpoint     = 12'd4095;
        temp         = 12'd0;
        check("ovr_before", {31'd0, overrun}, 32'd0);
        @(posedge clk); #1;            // E2
        sample_valid = 1'b0;
        check("ovr_pulse", {31'd0, overrun}, 32'd1);
        @(posedge clk); #1;            // E3
        check("ovr_clear", {31'd0, overrun}, 32'd0);
        check("ovr_dv_early", {31'd0, duty_valid}, 32'd0);
        @(posedge clk); #1;            // E4
        check("ovr_dv", {31'd0, duty_valid}, 32'd1);
        idle_cycles(6);
        check("ovr_single", {16'd0, duty}, 32'd106);

        // Disabled sample commits 0 and clears integ; next enabled sample gives 106
        run_sample(1000, 900, 1'b0);
        idle_cycles(1);
        check("dis_duty", {16'd0, duty}, 32'd0);
        run_sample(1000, 900, 1'b1);
        idle_cycles(1);

        // Reset while in MUL aborts without a duty_valid pulse
        setpoint     = 12'd1000;
        temp         = 12'd900;
        enable       = 1'b1;
        sample_valid = 1'b1;
        push_expect(1000, 900, 1'b1);
        @(posedge clk); #1;            // E0 -> ERR
        sample_valid = 1'b0;
        @(posedge clk); #1;            // E1 -> MUL
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        check("pre_abort_duty", {16'd0, duty}, 32'd106);
        void'(exp_q.pop_back());
        void'(exp_h_q.pop_back());
        do_reset();
        idle_cycles(8);
        check("abort_duty", {16'd0, duty}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);

        // Back-to-back: strobe in the duty_valid cycle is accepted
        run_sample(1000, 900, 1'b1);
        run_sample(1000, 900, 1'b1);
        idle_cycles(2);
        check("b2b_duty", {16'd0, duty}, 32'd112);

        idle_cycles(4);
        check("queue_empty", exp_q.size(), 32'd0);
        check("queue_hi_empty", exp_h_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pi_duty_controller.md
# pi_duty_controller

Closed-loop PI controller for the heater path. It takes one temperature sample and setpoint per `sample_valid` strobe and computes a saturated 16-bit duty word. That word drives the `duty` input of the downstream `pwm_generator`. Computation is a 4-cycle multi-stage FSM with anti-windup, so each result lands on a clean registered boundary.

## Interface
- `TEMP_W`, 12: width of `temp` and `setpoint` (unsigned)
- `KP`, 16'd256: proportional gain, unsigned, scaled by 2^FRAC
- `KI`, 16'd16: integral gain per sample, unsigned, scaled by 2^FRAC
- `FRAC`, 8: fractional bits removed from the final sum (arithmetic right shift)

- `clk`  in  1  single system clock
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  loop enable; low forces duty to 0 and clears the integrator
- `sample_valid`  in  1  one-cycle strobe; `temp` and `setpoint` are valid
- `temp`  in  TEMP_W  measured temperature code
- `setpoint`  in  TEMP_W  target temperature code
- `duty`  out  16  duty word for the PWM stage, registered
- `duty_valid`  out  1  one-cycle pulse; `duty` was updated this cycle
- `busy`  out  1  high while a computation is in flight
- `overrun`  out  1  one-cycle pulse when `sample_valid` arrives while busy

## Operation
- FSM states: IDLE → ERR → MUL → ACC → OUT → IDLE.
- `busy` = (state != IDLE).
- IDLE: on `sample_valid`, register `temp`, `setpoint` and `enable`, then go to ERR. If `sample_valid` arrives in any other state, the sample is dropped and `overrun` pulses.
- ERR: `err = setpoint - temp`, signed, TEMP_W+1 bits. Positive means too cold, so duty rises.
- MUL:
  - `p = KP*err`, signed, TEMP_W+17 bits.
  - `i_inc = KI*err`, same width.
- ACC:
  - `integ_c = integ + i_inc`, saturated to signed 32-bit limits.
  - `sum = p + integ_c`, signed 34 bits.
  - `u = sum >>> FRAC`.
- Clamp: u < 0 → 0; u > 65535 → 65535; otherwise u[15:0].
- Anti-windup: `integ` takes `integ_c` unless the clamp hit the high limit with err > 0, or hit the low limit with err < 0. In either of those cases `integ` holds its previous value.
- OUT: commit `duty` and `integ`, pulse `duty_valid`, return to IDLE.
- Latched `enable` = 0: `duty` commits 0, `integ` clears to 0, and `duty_valid` still pulses.
- `duty` holds its value between updates. The PWM stage consumes it continuously.

## Timing
- Reset values: `duty` = 0, `duty_valid` = 0, `busy` = 0, `overrun` = 0, `integ` = 0, state = IDLE.
- Reset mid-computation aborts immediately. No `duty_valid` pulse is produced for the aborted sample.
- Sample accepted at edge E0 → state ERR after E0, MUL after E1, ACC after E2, OUT after E3.
- New `duty` and `duty_valid` = 1 become visible after E4, with state back in IDLE. Latency is 4 clocks.
- `busy` is high for the 4 cycles after E0.
- The earliest next accepted sample is at E5. Maximum sample rate is 1 per 5 clocks.
- `sample_valid` in the same cycle that `duty_valid` is high is accepted, because the state is IDLE.
- `overrun` is registered and pulses the cycle after the dropped strobe.
- `temp`/`setpoint` changes after acceptance have no effect on the computation in flight.

## Structure
- Shared package `temp_ctrl_pkg` holds:
  - the state enum
  - `DUTY_W` = 16, `DUTY_MAX` = 16'hFFFF
  - `INTEG_W` = 32 and the signed integrator limits
- No sub-module is needed. The clamp/saturate helper is a package function shared with future loops.
- The block instantiates alongside `pwm_generator`; `duty` connects directly to its `duty` port.

## Test plan
- **Proportional + first integral step.** Reset, enable = 1, defaults (KP = 256, KI = 16, FRAC = 8), setpoint = 1000, temp = 900 → after 4 clocks `duty` = 106 with a one-cycle `duty_valid`. An identical second sample → `duty` = 112.
- **Negative error.** setpoint = 500, temp = 900 from reset → `duty` = 0 (clamped low), and `integ` stays 0.
- **High saturation / anti-windup.** KP = 65535, setpoint = 4095, temp = 0 → `duty` = 65535 and `integ` stays 0. Then setpoint = temp = 2000 → `duty` = 0, with no windup tail.
- **Overrun.** `sample_valid` at E0 and again at E2 → a single `duty_valid` at E4 reflecting the first sample, and `overrun` pulses once.
- **Disable and reset abort.**
  - `enable` = 0 with setpoint = 1000, temp = 900 → `duty` = 0 and `duty_valid` pulses. The next enabled sample gives 106 (integ was cleared).
  - `reset` asserted in MUL → all outputs return to reset values at once, and no `duty_valid` follows.
- **Back-to-back.** A sample strobed in the `duty_valid` cycle → accepted, with its result 4 clocks later.
